// File: rtl/ika2151_dac_pkg.sv
// ika2151_dac_pkg: shared constants and FSM state type for the serial DAC receiver
package ika2151_dac_pkg;
  localparam int WORD_BITS  = 16;
  localparam int MANT_LSB   = 3;
  localparam int EXP_LSB    = 13;
  localparam int SH_SPACING = 15;
  localparam int GAP_MAX    = 31;
  typedef enum logic [1:0] {HUNT, WAIT_SH2, WAIT_SH1} state_e;
endpackage

// File: rtl/ika2151_fp2lin.sv
// ika2151_fp2lin: 10-bit mantissa / 3-bit exponent float to signed 16-bit linear PCM
module ika2151_fp2lin #(
  parameter bit ZERO_EXP_MUTE = 1'b1
) (
  input  logic [9:0]  i_MANT,
  input  logic [2:0]  i_EXP,
  output logic [15:0] o_LIN
);
  logic signed [15:0] ext;
  // Mantissa is offset-binary: flipping the MSB gives two's complement.
  assign ext   = {{7{~i_MANT[9]}}, i_MANT[8:0]};
  assign o_LIN = (i_EXP == 3'd0) ? (ZERO_EXP_MUTE ? 16'h0000 : ext) : ext <<< (i_EXP - 3'd1);
endmodule

// File: rtl/ika2151_serial_dac_rx.sv
// ika2151_serial_dac_rx: YM3012-style serial DAC receiver with SH1/SH2 frame-spacing checker
module ika2151_serial_dac_rx
  import ika2151_dac_pkg::*;
#(
  parameter bit SWAP_LR       = 1'b0,
  parameter bit ZERO_EXP_MUTE = 1'b1
) (
  input  logic        i_EMUCLK,
  input  logic        i_IC_n,
  input  logic        i_phi1_NCEN_n,
  input  logic        i_SO,
  input  logic        i_SH1,
  input  logic        i_SH2,
  output logic [15:0] o_SAMPLE_L,
  output logic [15:0] o_SAMPLE_R,
  output logic        o_SAMPLE_VALID,
  output logic        o_LOCKED,
  output logic        o_FRAME_ERR
);
  state_e state_q, state_d;
  // Padding bits and the bit shifted out never reach the decoder, so only
  // the bits that can still land in the mantissa/exponent field are stored.
  logic [WORD_BITS-1:MANT_LSB+1] sr_q;
  logic [WORD_BITS-1:MANT_LSB]   sr_d;
  logic        sh1_q, sh2_q;
  logic [4:0]  gap_q, gap_d;
  logic [15:0] hold_l_q, hold_r_q, out_l_q, out_r_q, dec;
  logic        pend_q, valid_q, locked_q, ferr_q;
  logic        tick, sh1_fall, sh2_fall, both_fall, gap_ok, gap_max;
  logic        latch_l, latch_r, err;

  assign tick      = ~i_phi1_NCEN_n;
  assign sr_d      = {i_SO, sr_q};
  assign sh1_fall  = tick & sh1_q & ~i_SH1;
  assign sh2_fall  = tick & sh2_q & ~i_SH2;
  assign both_fall = sh1_fall & sh2_fall;
  assign gap_ok    = gap_q == 5'(SH_SPACING);
  assign gap_max   = gap_q == 5'(GAP_MAX);
  assign gap_d     = (latch_l | latch_r) ? 5'd0 : gap_q + {4'd0, ~gap_max};

  // One decoder serves both slots: L and R are never latched on the same tick.
  ika2151_fp2lin #(.ZERO_EXP_MUTE(ZERO_EXP_MUTE)) u_fp2lin (
    .i_MANT (sr_d[EXP_LSB-1:MANT_LSB]),
    .i_EXP  (sr_d[WORD_BITS-1:EXP_LSB]),
    .o_LIN  (dec)
  );

  // FSM state register
  always_ff @(posedge i_EMUCLK or negedge i_IC_n)
    if (!i_IC_n) state_q <= HUNT;
    else         state_q <= state_d;

  // FSM next state; simultaneous falls always drop back to HUNT
  always_comb begin
    state_d = state_q;
    case (state_q)
      HUNT:     state_d = sh1_fall ? WAIT_SH2 : HUNT;
      WAIT_SH2: state_d = sh2_fall ? (gap_ok ? WAIT_SH1 : HUNT) :
                          sh1_fall ? WAIT_SH2 : (tick & gap_max) ? HUNT : WAIT_SH2;
      WAIT_SH1: state_d = sh1_fall ? WAIT_SH2 : (sh2_fall | (tick & gap_max)) ? HUNT : WAIT_SH1;
      default:  state_d = HUNT;
    endcase
    if (both_fall) state_d = HUNT;
  end

  // FSM outputs: which slot to latch and whether the spacing was violated
  always_comb begin
    latch_l = sh1_fall & ~sh2_fall;
    latch_r = sh2_fall & ~sh1_fall & (state_q == WAIT_SH2) & gap_ok;
    err     = both_fall
            | ((state_q == WAIT_SH2) & (sh2_fall ? ~gap_ok : (sh1_fall | (tick & gap_max))))
            | ((state_q == WAIT_SH1) & (sh1_fall ? ~gap_ok : (sh2_fall | (tick & gap_max))));
  end

  // Datapath: shifter, strobe delays, gap counter, holding and output registers
  always_ff @(posedge i_EMUCLK or negedge i_IC_n)
    if (!i_IC_n) begin
      sr_q     <= '0;
      sh1_q    <= 1'b0;
      sh2_q    <= 1'b0;
      gap_q    <= 5'd0;
      hold_l_q <= 16'h0000;
      hold_r_q <= 16'h0000;
      out_l_q  <= 16'h0000;
      out_r_q  <= 16'h0000;
      pend_q   <= 1'b0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      pend_q  <= latch_r;
      if (tick) begin
        sr_q  <= sr_d[WORD_BITS-1:MANT_LSB+1];
        sh1_q <= i_SH1;
        sh2_q <= i_SH2;
        gap_q <= gap_d;
      end
      if (latch_l) hold_l_q <= dec;
      if (latch_r) hold_r_q <= dec;
      if (pend_q) begin
        out_l_q  <= SWAP_LR ? hold_r_q : hold_l_q;
        out_r_q  <= SWAP_LR ? hold_l_q : hold_r_q;
        valid_q  <= 1'b1;
        locked_q <= 1'b1;
      end
      if (err) begin
        ferr_q   <= 1'b1;
        locked_q <= 1'b0;
      end
    end

  assign o_SAMPLE_L     = out_l_q;
  assign o_SAMPLE_R     = out_r_q;
  assign o_SAMPLE_VALID = valid_q;
  assign o_LOCKED       = locked_q;
  assign o_FRAME_ERR    = ferr_q;
endmodule

// File: tb/tb_ika2151_serial_dac_rx.sv
// tb_ika2151_serial_dac_rx: scoreboard bench for three parameterisations of the serial DAC receiver
module tb_ika2151_serial_dac_rx;
  import ika2151_dac_pkg::*;

  logic clk = 1'b0, ic_n = 1'b0, ncen = 1'b1, so = 1'b0, sh1 = 1'b0, sh2 = 1'b0;
  logic [15:0] out_l[3], out_r[3];
  logic        valid[3], locked[3], ferr[3];
  int errors = 0, checks = 0, vcnt = 0, fcnt = 0, drops = 0;
  bit watch = 1'b0;
  logic [31:0] exp_q[3][$];
  logic [31:0] last_exp[3];

  // k=0 default, k=1 no zero-exponent mute, k=2 swapped channels
  ika2151_serial_dac_rx #(.SWAP_LR(1'b0), .ZERO_EXP_MUTE(1'b1)) dut0 (
    .i_EMUCLK(clk), .i_IC_n(ic_n), .i_phi1_NCEN_n(ncen), .i_SO(so), .i_SH1(sh1), .i_SH2(sh2),
    .o_SAMPLE_L(out_l[0]), .o_SAMPLE_R(out_r[0]), .o_SAMPLE_VALID(valid[0]),
    .o_LOCKED(locked[0]), .o_FRAME_ERR(ferr[0]));
  ika2151_serial_dac_rx #(.SWAP_LR(1'b0), .ZERO_EXP_MUTE(1'b0)) dut1 (
    .i_EMUCLK(clk), .i_IC_n(ic_n), .i_phi1_NCEN_n(ncen), .i_SO(so), .i_SH1(sh1), .i_SH2(sh2),
    .o_SAMPLE_L(out_l[1]), .o_SAMPLE_R(out_r[1]), .o_SAMPLE_VALID(valid[1]),
    .o_LOCKED(locked[1]), .o_FRAME_ERR(ferr[1]));
  ika2151_serial_dac_rx #(.SWAP_LR(1'b1), .ZERO_EXP_MUTE(1'b1)) dut2 (
    .i_EMUCLK(clk), .i_IC_n(ic_n), .i_phi1_NCEN_n(ncen), .i_SO(so), .i_SH1(sh1), .i_SH2(sh2),
    .o_SAMPLE_L(out_l[2]), .o_SAMPLE_R(out_r[2]), .o_SAMPLE_VALID(valid[2]),
    .o_LOCKED(locked[2]), .o_FRAME_ERR(ferr[2]));

  always #5 clk = ~clk;

  // Reference: offset-binary mantissa minus 512, scaled by 2^(E-1)
  function automatic logic [15:0] model(logic [15:0] w, bit mute);
    int m, e, v;
    m = int'(w[12:3]) - 512;
    e = int'(w[15:13]);
    v = (e == 0) ? (mute ? 0 : m) : m * (1 << (e - 1));
    return 16'(v);
  endfunction

  function automatic logic [15:0] mk(logic [9:0] m, logic [2:0] e);
    return {e, m, 3'b101};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every valid pulse, counts pulses
  always @(negedge clk) begin
    if (ferr[0]) fcnt++;
    if (valid[0]) vcnt++;
    if (watch && !locked[0]) drops++;
    for (int k = 0; k < 3; k++)
      if (valid[k]) begin
        if (exp_q[k].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid%0d: got %h expected no pulse", k, {out_l[k], out_r[k]});
        end else chk($sformatf("pair%0d", k), {out_l[k], out_r[k]}, exp_q[k].pop_front());
      end
  end

  task automatic do_tick(logic s, logic a, logic b, int stall);
    repeat (stall) begin
      ncen = 1'b1; so = 1'($urandom); sh1 = 1'($urandom); sh2 = 1'($urandom);
      @(posedge clk); #1;
    end
    ncen = 1'b0; so = s; sh1 = a; sh2 = b;
    @(posedge clk); #1;
    ncen = 1'b1;
  endtask

  // ch: 1=SH1, 2=SH2, 3=both; the strobe falls on the word's last tick
  task automatic send_word(logic [15:0] w, logic [1:0] ch, int n, int st);
    for (int i = 0; i < n; i++)
      do_tick(w[i], ch[0] && i < n - 1, ch[1] && i < n - 1, int'($urandom_range(st, 0)));
  endtask

  task automatic push_frame(logic [15:0] a, logic [15:0] b);
    logic [15:0] x, y;
    for (int k = 0; k < 3; k++) begin
      x = model(a, k != 1);
      y = model(b, k != 1);
      last_exp[k] = (k == 2) ? {y, x} : {x, y};
      exp_q[k].push_back(last_exp[k]);
    end
  endtask

  task automatic frame(logic [15:0] a, logic [15:0] b, int st);
    push_frame(a, b);
    send_word(a, 2'd1, 16, st);
    send_word(b, 2'd2, 16, st);
  endtask

  task automatic settle();
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int v0, f0;
    logic [31:0] held;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_lr%0d", k), {out_l[k], out_r[k]}, 32'h0);
      chk($sformatf("rst_flags%0d", k), {29'd0, valid[k], locked[k], ferr[k]}, 32'h0);
    end
    ic_n = 1'b1;
    settle();
    // Full-scale words
    frame(mk(10'h3FF, 3'd7), mk(10'h000, 3'd7), 0);
    settle();
    chk("t1_L", 32'(out_l[0]), 32'h7FC0);
    chk("t1_R", 32'(out_r[0]), 32'h8000);
    chk("t1_swapR", 32'(out_r[2]), 32'h7FC0);
    chk("t1_locked", 32'(locked[0]), 32'd1);
    chk("t1_vcnt", 32'(vcnt), 32'd1);
    // Small exponents and zero exponent, with stalled enables
    frame(mk(10'h201, 3'd1), mk(10'h200, 3'd3), 2);
    settle();
    chk("t2_L", 32'(out_l[0]), 32'h0001);
    chk("t2_R", 32'(out_r[0]), 32'h0000);
    frame(mk(10'h3FF, 3'd0), mk(10'h3FF, 3'd0), 0);
    settle();
    chk("t2_mute", 32'(out_l[0]), 32'h0000);
    chk("t2_nomute", 32'(out_l[1]), 32'h01FF);
    // 100 continuous frames
    v0 = vcnt;
    watch = 1'b1;
    for (int i = 0; i < 100; i++) frame(16'($urandom), 16'($urandom), (i % 10 == 0) ? 2 : 0);
    settle();
    watch = 1'b0;
    chk("t3_vcnt", 32'(vcnt - v0), 32'd100);
    chk("t3_lock_drops", 32'(drops), 32'd0);
    // SH2 one tick early
    f0 = fcnt; v0 = vcnt; held = last_exp[0];
    send_word(16'($urandom), 2'd1, 16, 0);
    send_word(16'($urandom), 2'd2, 15, 0);
    settle();
    chk("t4_ferr", 32'(fcnt - f0), 32'd1);
    chk("t4_locked", 32'(locked[0]), 32'd0);
    chk("t4_held", {out_l[0], out_r[0]}, held);
    chk("t4_novalid", 32'(vcnt - v0), 32'd0);
    frame(16'($urandom), 16'($urandom), 0);
    settle();
    chk("t4_relock", 32'(locked[0]), 32'd1);
    // Simultaneous falls, then silence
    f0 = fcnt; v0 = vcnt;
    send_word(16'($urandom), 2'd3, 16, 0);
    repeat (40) do_tick(1'b0, 1'b0, 1'b0, 0);
    settle();
    chk("t5_ferr", 32'(fcnt - f0), 32'd1);
    chk("t5_state", 32'(dut0.state_q), 32'(HUNT));
    chk("t5_novalid", 32'(vcnt - v0), 32'd0);
    chk("t5_locked", 32'(locked[0]), 32'd0);
    // Reset while waiting for SH2
    send_word(16'($urandom), 2'd1, 16, 0);
    for (int i = 0; i < 5; i++) do_tick(1'b1, 1'b0, 1'b1, 0);
    #2 ic_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("t6_lr%0d", k), {out_l[k], out_r[k]}, 32'h0);
      chk($sformatf("t6_flags%0d", k), {29'd0, valid[k], locked[k], ferr[k]}, 32'h0);
    end
    @(posedge clk);
    #1 ic_n = 1'b1;
    frame(mk(10'h3FF, 3'd7), mk(10'h201, 3'd1), 0);
    settle();
    chk("t6_swapR", 32'(out_r[2]), 32'h7FC0);
    chk("t6_swapL", 32'(out_l[2]), 32'h0001);
    chk("t6_locked", 32'(locked[2]), 32'd1);
    for (int k = 0; k < 3; k++) chk($sformatf("pending%0d", k), 32'(exp_q[k].size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
